// File: rtl/tlp_pkg.sv
// Shared definitions for the TLP TX command path: requester ids, arbiter
// state encoding and the default descriptor width.
package tlp_pkg;

  localparam int unsigned C_CMD_WIDTH_DEF = 64;
  localparam int unsigned NUM_REQ         = 3;
  localparam int unsigned REQ_ID_W        = 2;

  typedef logic [REQ_ID_W-1:0] req_id_t;

  localparam req_id_t REQ_CPL = 2'd0;
  localparam req_id_t REQ_MWR = 2'd1;
  localparam req_id_t REQ_MRD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_STALL = 2'd2
  } arb_state_t;

  // Next requester in rotating order, wrapping MRD back to CPL.
  function automatic req_id_t rr_next(input req_id_t id);
    return (id >= REQ_MRD) ? REQ_CPL : req_id_t'(id + req_id_t'(1));
  endfunction

endpackage

// File: rtl/tlp_rr_pick3.sv
// Three-way rotating priority pick with CPL strict-priority option and a
// starvation override that always takes precedence.
module tlp_rr_pick3
  import tlp_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  req_id_t            ptr,
  input  logic               cpl_prio,
  input  logic [NUM_REQ-1:0] starved,
  output logic               any_c,
  output req_id_t            idx_c,
  output logic [NUM_REQ-1:0] onehot_c
);

  logic [NUM_REQ-1:0] starv;
  req_id_t            cand;

  assign starv = starved & valid;

  always_comb begin
    any_c = 1'b0;
    idx_c = REQ_CPL;
    cand  = rr_next(ptr);
    if (|starv) begin
      any_c = 1'b1;
      if (starv[REQ_CPL])      idx_c = REQ_CPL;
      else if (starv[REQ_MWR]) idx_c = REQ_MWR;
      else                     idx_c = REQ_MRD;
    end else if (cpl_prio && valid[REQ_CPL]) begin
      any_c = 1'b1;
      idx_c = REQ_CPL;
    end else begin
      // Walk the ring starting one past the last winner.
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (!any_c && valid[cand]) begin
          any_c = 1'b1;
          idx_c = cand;
        end
        cand = rr_next(cand);
      end
    end
  end

  assign onehot_c = any_c ? (NUM_REQ'(1) << idx_c) : '0;

endmodule

// File: rtl/tlp_txcmd_arb.sv
// Arbitrates CPL/MWR/MRD command descriptors into the TX command FIFO with a
// fixed one-cycle write latency, per-requester grant counters and anti-starvation.
module tlp_txcmd_arb
  import tlp_pkg::*;
#(
  parameter int unsigned C_CMD_WIDTH  = C_CMD_WIDTH_DEF,
  parameter int unsigned C_STARVE_MAX = 15
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*C_CMD_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           cfg_cpl_prio,
  input  logic                           fifo_afull,
  output logic                           fifo_wr,
  output logic [C_CMD_WIDTH-1:0]         fifo_wdata,
  output logic [1:0]                     fifo_wsrc,
  output logic [NUM_REQ*16-1:0]          grant_cnt
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WAIT_W = ($clog2(C_STARVE_MAX + 1) > 4) ? $clog2(C_STARVE_MAX + 1) : 4;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(C_STARVE_MAX);

  arb_state_t               state, state_nxt;
  req_id_t                  rr_ptr;
  logic [WAIT_W-1:0]        wait_cnt [NUM_REQ];
  logic [CNT_W-1:0]         gcnt     [NUM_REQ];
  logic [NUM_REQ-1:0]       starved;
  logic [NUM_REQ-1:0]       hs;
  logic                     pick_any_c;
  req_id_t                  pick_idx_c;
  logic [NUM_REQ-1:0]       pick_onehot_c;
  logic [C_CMD_WIDTH-1:0]   pick_data_c;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      starved[i]                    = (wait_cnt[i] == WAIT_MAX);
      grant_cnt[i*CNT_W +: CNT_W]   = gcnt[i];
    end
  end

  tlp_rr_pick3 u_pick (
    .valid    (req_valid),
    .ptr      (rr_ptr),
    .cpl_prio (cfg_cpl_prio),
    .starved  (starved),
    .any_c    (pick_any_c),
    .idx_c    (pick_idx_c),
    .onehot_c (pick_onehot_c)
  );

  // Descriptor of the current winner; only sampled on a handshake.
  always_comb begin
    pick_data_c = req_data[C_CMD_WIDTH-1:0];
    for (int unsigned i = 1; i < NUM_REQ; i++) begin
      if (pick_idx_c == req_id_t'(i)) pick_data_c = req_data[i*C_CMD_WIDTH +: C_CMD_WIDTH];
    end
  end

  assign hs = req_valid & req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // A late fifo_afull still lets the current grant through; STALL stops the next one.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      ST_IDLE:  if (|req_valid) state_nxt = ST_ARB;
      ST_ARB: begin
        req_ready = pick_onehot_c;
        if (fifo_afull)       state_nxt = ST_STALL;
        else if (!pick_any_c) state_nxt = ST_IDLE;
      end
      ST_STALL: if (!fifo_afull) state_nxt = ST_ARB;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= REQ_MRD;
      fifo_wr    <= 1'b0;
      fifo_wdata <= '0;
      fifo_wsrc  <= '0;
    end else begin
      fifo_wr <= |hs;
      if (|hs) begin
        rr_ptr     <= pick_idx_c;
        fifo_wdata <= pick_data_c;
        fifo_wsrc  <= pick_idx_c;
      end
    end
  end

  // Wait counters only advance on lost arbitration cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        wait_cnt[i] <= '0;
        gcnt[i]     <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] || hs[i])
          wait_cnt[i] <= '0;
        else if (state == ST_ARB && wait_cnt[i] != WAIT_MAX)
          wait_cnt[i] <= wait_cnt[i] + WAIT_W'(1);
        if (hs[i]) gcnt[i] <= gcnt[i] + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tlp_txcmd_arb.sv
// Bench for tlp_txcmd_arb: per-cycle vector table plus hand-written corner
// sequences; expected FIFO writes are queued on each expected grant.
module tb_tlp_txcmd_arb;

  localparam int unsigned W = 64;

  typedef struct {
    logic [2:0] v;
    logic       p;
    logic       af;
    logic [2:0] rdy;
  } vec_t;

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   src;
  } sb_t;

  logic           clk;
  logic           rst_n;
  logic [2:0]     req_valid;
  logic [3*W-1:0] req_data;
  logic [2:0]     req_ready;
  logic           cfg_cpl_prio;
  logic           fifo_afull;
  logic           fifo_wr;
  logic [W-1:0]   fifo_wdata;
  logic [1:0]     fifo_wsrc;
  logic [47:0]    grant_cnt;

  int           n_tests;
  int           n_fail;
  int           f0;
  sb_t          sbq[$];
  vec_t         tbl[$];
  logic [W-1:0] dat [3];
  logic [15:0]  exp_cnt [3];

  tlp_txcmd_arb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .cfg_cpl_prio (cfg_cpl_prio),
    .fifo_afull   (fifo_afull),
    .fifo_wr      (fifo_wr),
    .fifo_wdata   (fifo_wdata),
    .fifo_wsrc    (fifo_wsrc),
    .grant_cnt    (grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] v, input logic p, input logic af, input logic [2:0] r);
    vec_t x;
    x.v = v; x.p = p; x.af = af; x.rdy = r;
    tbl.push_back(x);
  endtask

  // One clock: drive, then check the FIFO write owed from the previous cycle and this cycle's ready.
  task automatic step(input string tag, input logic [2:0] v, input logic p, input logic af,
                      input logic [2:0] rdy);
    sb_t        e;
    int         idx;
    logic [2:0] h;
    @(posedge clk);
    #1;
    req_valid    = v;
    cfg_cpl_prio = p;
    fifo_afull   = af;
    req_data     = {dat[2], dat[1], dat[0]};
    #3;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, ".fifo_wr"}, 64'(fifo_wr), 64'd1);
      chk({tag, ".fifo_wdata"}, 64'(fifo_wdata), 64'(e.data));
      chk({tag, ".fifo_wsrc"}, 64'(fifo_wsrc), 64'(e.src));
    end else begin
      chk({tag, ".fifo_wr"}, 64'(fifo_wr), 64'd0);
    end
    chk({tag, ".req_ready"}, 64'(req_ready), 64'(rdy));
    h = v & rdy;
    if (h != 3'b000) begin
      idx = h[0] ? 0 : (h[1] ? 1 : 2);
      e.data = dat[idx];
      e.src  = 2'(idx);
      sbq.push_back(e);
      exp_cnt[idx] = exp_cnt[idx] + 16'd1;
      dat[idx] = {$urandom(), $urandom()};
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, ".grant_cnt"}, 64'(grant_cnt), 64'({exp_cnt[2], exp_cnt[1], exp_cnt[0]}));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    req_valid = '0;
    cfg_cpl_prio = 1'b0;
    fifo_afull = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dat[i] = {$urandom(), $urandom()};
      exp_cnt[i] = '0;
    end
    req_data = {dat[2], dat[1], dat[0]};

    repeat (2) @(posedge clk);
    #4;
    chk("rst.req_ready", 64'(req_ready), 64'd0);
    chk("rst.fifo_wr", 64'(fifo_wr), 64'd0);
    chk("rst.fifo_wdata", 64'(fifo_wdata), 64'd0);
    chk("rst.fifo_wsrc", 64'(fifo_wsrc), 64'd0);
    chk("rst.grant_cnt", 64'(grant_cnt), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Round-robin from reset: CPL first, then rotating.
    add(3'b111, 0, 0, 3'b000);
    add(3'b111, 0, 0, 3'b001);
    add(3'b111, 0, 0, 3'b010);
    add(3'b111, 0, 0, 3'b100);
    add(3'b111, 0, 0, 3'b001);
    add(3'b111, 0, 0, 3'b010);
    add(3'b111, 0, 0, 3'b100);
    add(3'b000, 0, 0, 3'b000);
    add(3'b000, 0, 0, 3'b000);
    // Almost-full pulse: grant in the afull cycle survives, then three dead cycles.
    add(3'b010, 0, 0, 3'b000);
    add(3'b010, 0, 0, 3'b010);
    add(3'b010, 0, 1, 3'b010);
    add(3'b010, 0, 1, 3'b000);
    add(3'b010, 0, 1, 3'b000);
    add(3'b010, 0, 0, 3'b000);
    add(3'b010, 0, 0, 3'b010);
    add(3'b010, 0, 0, 3'b010);
    add(3'b000, 0, 0, 3'b000);
    // Priority mode toggled mid-stream.
    add(3'b111, 0, 0, 3'b000);
    add(3'b111, 0, 0, 3'b100);
    add(3'b111, 1, 0, 3'b001);
    add(3'b111, 0, 0, 3'b010);
    add(3'b111, 0, 0, 3'b100);
    add(3'b000, 0, 0, 3'b000);

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("vec%0d", i), tbl[i].v, tbl[i].p, tbl[i].af, tbl[i].rdy);
    chk_cnt("after_table");

    // CPL strict priority until MWR starves on its 16th arbitration.
    step("starve_idle", 3'b011, 1, 0, 3'b000);
    for (int k = 1; k <= 15; k++) step($sformatf("starve_cpl%0d", k), 3'b011, 1, 0, 3'b001);
    step("starve_mwr", 3'b011, 1, 0, 3'b010);
    step("starve_cpl_again", 3'b011, 1, 0, 3'b001);
    step("starve_drop", 3'b000, 1, 0, 3'b000);
    step("starve_idle2", 3'b000, 0, 0, 3'b000);

    // Single descriptor round trip, then check the arbiter fell back to IDLE.
    dat[0] = 64'hDEADBEEF_00000001;
    step("one_idle", 3'b001, 0, 0, 3'b000);
    step("one_grant", 3'b001, 0, 0, 3'b001);
    step("one_write", 3'b000, 0, 0, 3'b000);
    chk("one.wdata_const", 64'(fifo_wdata), 64'hDEADBEEF_00000001);
    step("one_quiet", 3'b000, 0, 0, 3'b000);
    step("one_reidle", 3'b010, 0, 0, 3'b000);
    step("one_regrant", 3'b010, 0, 0, 3'b010);
    step("one_end", 3'b000, 0, 0, 3'b000);
    step("one_end2", 3'b000, 0, 0, 3'b000);
    chk_cnt("after_single");

    // Reset while a FIFO write is in flight.
    step("r_idle", 3'b011, 1, 0, 3'b000);
    step("r_g0", 3'b011, 1, 0, 3'b001);
    step("r_g1", 3'b011, 1, 0, 3'b001);
    #1 rst_n = 1'b0;
    #1;
    chk("rmid.fifo_wr", 64'(fifo_wr), 64'd0);
    chk("rmid.req_ready", 64'(req_ready), 64'd0);
    chk("rmid.grant_cnt", 64'(grant_cnt), 64'd0);
    chk("rmid.fifo_wdata", 64'(fifo_wdata), 64'd0);
    chk("rmid.fifo_wsrc", 64'(fifo_wsrc), 64'd0);
    sbq.delete();
    for (int i = 0; i < 3; i++) exp_cnt[i] = '0;
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = 3'b011;
    cfg_cpl_prio = 1'b0;
    req_data = {dat[2], dat[1], dat[0]};
    #3;
    chk("rrel.req_ready", 64'(req_ready), 64'd0);
    chk("rrel.fifo_wr", 64'(fifo_wr), 64'd0);
    step("rrel_cpl", 3'b011, 0, 0, 3'b001);
    step("rrel_mwr", 3'b011, 0, 0, 3'b010);
    step("rrel_drop", 3'b000, 0, 0, 3'b000);
    step("rrel_idle", 3'b000, 0, 0, 3'b000);
    chk_cnt("after_reset");

    // MRD grant counter wrap.
    step("bulk_idle", 3'b100, 0, 0, 3'b000);
    f0 = n_fail;
    for (int i = 0; i < 65535; i++) begin
      step("bulk", 3'b100, 0, 0, 3'b100);
      if (n_fail != f0) break;
    end
    step("bulk_last", 3'b100, 0, 0, 3'b100);
    chk("bulk.mrd_ffff", 64'(grant_cnt[47:32]), 64'hFFFF);
    step("bulk_end", 3'b000, 0, 0, 3'b000);
    chk("bulk.mrd_wrap", 64'(grant_cnt[47:32]), 64'd0);
    chk("bulk.cpl_kept", 64'(grant_cnt[15:0]), 64'd1);
    chk("bulk.mwr_kept", 64'(grant_cnt[31:16]), 64'd1);
    chk_cnt("after_bulk");
    step("final_idle", 3'b000, 0, 0, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
